// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   NOP_INST       canonical NOP (addi x0, x0, 0) used for bubbles
//   BIOS_BASE_NIB  PC[31:28] value selecting the BIOS ROM
//   IMEM_BASE_NIB  PC[31:28] value selecting the instruction memory
//   fetch_src_t    which memory (if any) services a fetch
package riscv_pkg;

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [3:0]  BIOS_BASE_NIB = 4'h4;
  localparam logic [3:0]  IMEM_BASE_NIB = 4'h1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BIOS = 2'd1,
    SRC_IMEM = 2'd2
  } fetch_src_t;

endpackage

// File: rtl/fetch_addr_decode.sv
// Fetch address decoder: maps a PC onto the memory that services it.
//   pc   in   32  fetch PC
//   src  out  --  SRC_BIOS / SRC_IMEM / SRC_NONE (unmapped)
// Only the top nibble participates; word offsets are the memory's concern.
module fetch_addr_decode
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  output fetch_src_t  src
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    src = SRC_NONE;
    if (pc[31:28] == BIOS_BASE_NIB) begin
      src = SRC_BIOS;
    end else if (pc[31:28] == IMEM_BASE_NIB) begin
      src = SRC_IMEM;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the synchronous-read BIOS
// and IMEM, and presents {inst, inst_pc, inst_valid} aligned to decode.
//   clk, rst_n     clock / asynchronous active-low reset
//   stall          decode not accepting; the current slot is held
//   redirect       execute redirect (taken branch / jal / jalr)
//   redirect_pc    redirect target (low two bits ignored, flagged as fault)
//   bios_addr      BIOS word address, data returns next cycle on bios_dout
//   imem_addr      IMEM word address, data returns next cycle on imem_dout
//   inst           instruction for decode (NOP when not valid)
//   inst_pc        PC of inst
//   inst_valid     inst is real and on-path
//   fetch_fault    sticky: misaligned redirect or unmapped fetch seen
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          IMEM_AW  = 14,
  parameter int          BIOS_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid,
  output logic               fetch_fault
);

  // pc_q is the PC whose data is returning from memory this cycle; it starts
  // one word before RESET_PC so that inst_pc is coherent during the bubble.
  logic [31:0] pc_q,    pc_d;
  fetch_src_t  src_q,   src_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        slot_live;

  // Next-PC selection. Redirect outranks stall; a stall re-reads pc_q so the
  // memory output (and therefore inst) stays put while decode is blocked.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!valid_q) begin
      pc_d = RESET_PC;
    end
  end

  fetch_addr_decode u_decode (
    .pc  (pc_d),
    .src (src_d)
  );

  assign bios_addr = pc_d[BIOS_AW+1:2];
  assign imem_addr = pc_d[IMEM_AW+1:2];

  // valid_q only marks that the post-reset bubble is over.
  assign valid_d = 1'b1;
  assign fault_d = fault_q
                 | (redirect && (redirect_pc[1:0] != 2'b00))
                 | (src_d == SRC_NONE);

  // NOTE: state flops use non-blocking assignments under an asynchronous
  // reset so every register samples its pre-edge inputs, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC - 32'd4;
      src_q   <= SRC_NONE;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // A redirect kills the slot in the same cycle (the wrong-path instruction
  // must never reach decode as valid).
  assign slot_live = valid_q && (src_q != SRC_NONE) && !redirect;

  always_comb begin
    inst = NOP_INST;
    if (slot_live) begin
      inst = (src_q == SRC_BIOS) ? bios_dout : imem_dout;
    end
  end

  assign inst_pc     = pc_q;
  assign inst_valid  = slot_live;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// randomized stall/redirect traffic, all compared against a slot-level model.
module tb_inst_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] bios_dout = 32'h0;
  logic [31:0] imem_dout = 32'h0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, fetch_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: PC of the current slot, whether the post-reset
  // bubble has passed, and the sticky fault.
  logic [31:0] m_pc;
  logic        m_started;
  logic        m_fault;

  inst_fetch_unit #(
    .RESET_PC (RESET_PC),
    .IMEM_AW  (14),
    .BIOS_AW  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bios_addr   (bios_addr),
    .bios_dout   (bios_dout),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents are a pure function of the word address so the model can
  // predict them; the two memories carry distinct tags.
  function automatic logic [31:0] bios_word(input logic [11:0] a);
    return {8'hB1, 12'h000, a};
  endfunction

  function automatic logic [31:0] imem_word(input logic [13:0] a);
    return {8'h1E, 10'h000, a};
  endfunction

  // Synchronous-read memories: data for the address of this edge appears
  // after the edge.
  always @(posedge clk) begin
    bios_dout <= bios_word(bios_addr);
    imem_dout <= imem_word(imem_addr);
  end

  // 0 = unmapped, 1 = BIOS, 2 = IMEM
  function automatic int region(input logic [31:0] pc);
    if ((pc >> 28) == 32'd4) return 1;
    if ((pc >> 28) == 32'd1) return 2;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC - 32'd4;
    m_started = 1'b0;
    m_fault   = 1'b0;
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs against
  // the model, then advance the model across the rising edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] exp_inst, npc;
    logic        exp_valid;
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rpc;
    #1;
    exp_valid = m_started && (region(m_pc) != 0) && !r;
    if (!exp_valid)             exp_inst = 32'h0000_0013;
    else if (region(m_pc) == 1) exp_inst = bios_word(m_pc[13:2]);
    else                        exp_inst = imem_word(m_pc[15:2]);
    check("inst",        inst,        exp_inst);
    check("inst_pc",     inst_pc,     m_pc);
    check("inst_valid",  {31'b0, inst_valid},  {31'b0, exp_valid});
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    if (r)             npc = rpc & ~32'd3;
    else if (s)        npc = m_pc;
    else if (!m_started) npc = RESET_PC;
    else               npc = m_pc + 32'd4;
    @(posedge clk);
    if ((r && rpc[1:0] != 2'b00) || region(npc) == 0) m_fault = 1'b1;
    m_pc      = npc;
    m_started = 1'b1;
  endtask

  // Registered outputs checked against fixed scenario values, just after an edge.
  task automatic expect_state(input string tag, input logic [31:0] pc, input logic fault);
    #1;
    check({tag, "_pc"},    inst_pc,              pc);
    check({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, fault});
  endtask

  logic [31:0] rpc;
  int          sel;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset release and sequential fetch.
    step(0, 0, 0);                 expect_state("first", 32'h4000_0000, 0);
    step(0, 0, 0);
    step(0, 0, 0);                 expect_state("seq", 32'h4000_0008, 0);

    // Three-cycle stall holds the slot.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);               expect_state("stall", 32'h4000_0008, 0);
    end
    step(0, 0, 0);                 expect_state("resume", 32'h4000_000C, 0);
    step(0, 0, 0);                 expect_state("pre_redir", 32'h4000_0010, 0);

    // Redirect into IMEM.
    step(0, 1, 32'h1000_0020);     expect_state("redir_imem", 32'h1000_0020, 0);
    step(0, 0, 0);
    step(0, 0, 0);                 expect_state("imem_seq", 32'h1000_0028, 0);

    // Redirect together with stall: redirect wins.
    step(1, 1, 32'h4000_0100);     expect_state("redir_stall", 32'h4000_0100, 0);
    step(0, 0, 0);                 expect_state("after_rs", 32'h4000_0104, 0);

    // Misaligned redirect: aligned fetch, sticky fault.
    step(0, 1, 32'h1000_0022);     expect_state("misalign", 32'h1000_0020, 1);
    step(0, 0, 0);
    step(0, 0, 0);                 expect_state("sticky", 32'h1000_0028, 1);

    // Unmapped redirect produces a NOP bubble.
    step(0, 1, 32'h2000_0000);     expect_state("unmapped", 32'h2000_0000, 1);
    step(0, 0, 0);

    // Run off the top of the BIOS window into unmapped space.
    step(0, 1, 32'h4FFF_FFF8);
    step(0, 0, 0);
    step(0, 0, 0);                 expect_state("bios_top", 32'h5000_0000, 1);
    step(0, 0, 0);

    // Asynchronous reset mid-run.
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc",    inst_pc,              RESET_PC - 32'd4);
    check("rst_valid", {31'b0, inst_valid},  32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step(0, 0, 0);                 expect_state("restart", RESET_PC, 0);
    step(0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9)       rpc = 32'h4000_0000 | ($urandom_range(0, 1023) << 2);
      else if (sel < 18) rpc = 32'h1000_0000 | ($urandom_range(0, 4095) << 2);
      else if (sel == 18) rpc = 32'h1000_0040 | $urandom_range(1, 3);
      else               rpc = 32'h8000_0000;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
